// File: rtl/mac_sequencer.sv
// Sequences input vectors into a MAC: weight addressing, sum start/zeroing and result-valid timing.
// Define MAC_SEQ_SUM_CNT_EN to add the 16-bit sum_cnt output counting completed sums.
module mac_sequencer #(
   parameter int NUM_CYC = 32,
   parameter int ACC_LAT = 4,
   parameter int AW      = (NUM_CYC > 1) ? $clog2(NUM_CYC) : 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          vld_in,
   input  logic          flush,
   output logic          new_sum,
   output logic [AW-1:0] w_addr,
   output logic          w_zero,
   output logic          vld_out,
   output logic          busy
`ifdef MAC_SEQ_SUM_CNT_EN
   ,
   output logic [15:0]   sum_cnt
`endif
);

   typedef enum logic {IDLE, ACCUM} state_t;

   localparam logic [AW-1:0] LAST_IDX = AW'(NUM_CYC - 1);

   state_t             state;
   logic [AW-1:0]      cnt;
   logic [ACC_LAT-1:0] pipe;
   logic [ACC_LAT-1:0] pipe_next;
   logic               accept;
   logic               last;

   // NOTE: every signal gets a value on every path through always_comb, so no latch is inferred.
   always_comb begin
      // rst and flush both gate acceptance, which also keeps new_sum low and w_zero high during reset
      accept  = vld_in & ~flush & ~rst;
      new_sum = accept & (state == IDLE);
      w_zero  = ~accept;
      if (state == IDLE) last = accept & (NUM_CYC == 1);
      else               last = accept & (cnt == LAST_IDX);
      pipe_next    = pipe << 1;
      pipe_next[0] = last;
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
         pipe  <= '0;
      end else begin
         // in-flight results keep shifting even when the current sum is flushed
         pipe <= pipe_next;
         if (flush) begin
            state <= IDLE;
            cnt   <= '0;
         end else if (accept) begin
            if (last) begin
               state <= IDLE;
               cnt   <= '0;
            end else begin
               state <= ACCUM;
               cnt   <= cnt + AW'(1);
            end
         end
      end
   end

   assign w_addr  = cnt;
   assign vld_out = pipe[ACC_LAT-1];
   assign busy    = (state == ACCUM) | (|pipe);

`ifdef MAC_SEQ_SUM_CNT_EN
   always_ff @(posedge clk) begin
      if (rst)          sum_cnt <= '0;
      else if (vld_out) sum_cnt <= sum_cnt + 16'd1;
   end
`endif

endmodule

// File: tb/tb_mac_sequencer.sv
// Self-checking bench for mac_sequencer: two instances (4-vector and 1-vector sums) share stimulus
// and are compared every cycle against a completion-time model, plus directed scenario checks.
module tb_mac_sequencer;

   logic clk = 1'b0;
   logic rst, vld_in, flush;

   logic       ns4, wz4, vo4, bz4;
   logic [1:0] wa4;
   logic       ns1, wz1, vo1, bz1;
   logic [0:0] wa1;
`ifdef MAC_SEQ_SUM_CNT_EN
   logic [15:0] sc4, sc1;
`endif

   int checks = 0;
   int errors = 0;

   // model: vectors in current sum, due cycles of in-flight results, completed-sum count
   int m_n[2];
   int m_due[2][16];
   int m_sc[2];
   int cyc = 0;
   int lc  = 0;

   logic        lg_ns[2][64];
   logic        lg_wz[2][64];
   logic        lg_vo[2][64];
   logic        lg_bz[2][64];
   logic [15:0] lg_wa[2][64];

   always #5 clk = ~clk;

   mac_sequencer #(.NUM_CYC(4), .ACC_LAT(4)) dut4 (
      .clk(clk), .rst(rst), .vld_in(vld_in), .flush(flush),
      .new_sum(ns4), .w_addr(wa4), .w_zero(wz4), .vld_out(vo4), .busy(bz4)
`ifdef MAC_SEQ_SUM_CNT_EN
      , .sum_cnt(sc4)
`endif
   );

   mac_sequencer #(.NUM_CYC(1), .ACC_LAT(2)) dut1 (
      .clk(clk), .rst(rst), .vld_in(vld_in), .flush(flush),
      .new_sum(ns1), .w_addr(wa1), .w_zero(wz1), .vld_out(vo1), .busy(bz1)
`ifdef MAC_SEQ_SUM_CNT_EN
      , .sum_cnt(sc1)
`endif
   );

   function automatic int nc(input int d);
      return (d == 0) ? 4 : 1;
   endfunction

   function automatic int al(input int d);
      return (d == 0) ? 4 : 2;
   endfunction

   task automatic step(input logic v, input logic f, input logic r, input logic chk);
      logic        acc, e_ns, e_wz, e_vo, e_bz;
      logic [15:0] e_wa;
      logic        o_ns[2], o_wz[2], o_vo[2], o_bz[2];
      logic [15:0] o_wa[2];
      logic [15:0] o_sc[2];
      vld_in = v;
      flush  = f;
      rst    = r;
      @(negedge clk);
      o_ns = '{ns4, ns1};
      o_wz = '{wz4, wz1};
      o_vo = '{vo4, vo1};
      o_bz = '{bz4, bz1};
      o_wa = '{16'(wa4), 16'(wa1)};
`ifdef MAC_SEQ_SUM_CNT_EN
      o_sc = '{sc4, sc1};
`else
      o_sc = '{16'd0, 16'd0};
`endif
      for (int d = 0; d < 2; d++) begin
         acc  = v && !f && !r;
         e_ns = acc && (m_n[d] == 0);
         e_wz = !acc;
         e_wa = 16'(m_n[d]);
         e_vo = 1'b0;
         e_bz = (m_n[d] > 0);
         for (int k = 0; k < 16; k++) begin
            if (m_due[d][k] >= 0) begin
               e_bz = 1'b1;
               if (m_due[d][k] == cyc) e_vo = 1'b1;
            end
         end
         if (chk) begin
            checks += 5;
            if (o_ns[d] !== e_ns) begin errors++; $display("FAIL new_sum dut%0d cyc %0d: got %b want %b", d, cyc, o_ns[d], e_ns); end
            if (o_wz[d] !== e_wz) begin errors++; $display("FAIL w_zero dut%0d cyc %0d: got %b want %b", d, cyc, o_wz[d], e_wz); end
            if (o_wa[d] !== e_wa) begin errors++; $display("FAIL w_addr dut%0d cyc %0d: got %0d want %0d", d, cyc, o_wa[d], e_wa); end
            if (o_vo[d] !== e_vo) begin errors++; $display("FAIL vld_out dut%0d cyc %0d: got %b want %b", d, cyc, o_vo[d], e_vo); end
            if (o_bz[d] !== e_bz) begin errors++; $display("FAIL busy dut%0d cyc %0d: got %b want %b", d, cyc, o_bz[d], e_bz); end
`ifdef MAC_SEQ_SUM_CNT_EN
            checks++;
            if (o_sc[d] !== 16'(m_sc[d])) begin errors++; $display("FAIL sum_cnt dut%0d cyc %0d: got %0d want %0d", d, cyc, o_sc[d], m_sc[d]); end
`endif
         end
         if (lc < 64) begin
            lg_ns[d][lc] = o_ns[d];
            lg_wz[d][lc] = o_wz[d];
            lg_vo[d][lc] = o_vo[d];
            lg_bz[d][lc] = o_bz[d];
            lg_wa[d][lc] = o_wa[d];
         end
         if (e_vo) m_sc[d] = (m_sc[d] + 1) & 16'hFFFF;
         for (int k = 0; k < 16; k++) if (m_due[d][k] == cyc) m_due[d][k] = -1;
         if (r) begin
            m_n[d]  = 0;
            m_sc[d] = 0;
            for (int k = 0; k < 16; k++) m_due[d][k] = -1;
         end else if (f) begin
            m_n[d] = 0;
         end else if (acc) begin
            if (m_n[d] + 1 == nc(d)) begin
               m_n[d] = 0;
               for (int k = 0; k < 16; k++) begin
                  if (m_due[d][k] < 0) begin
                     m_due[d][k] = cyc + al(d);
                     break;
                  end
               end
            end else begin
               m_n[d]++;
            end
         end
      end
      lc++;
      cyc++;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b1);
   endtask

   task automatic test_reset();
      for (int d = 0; d < 2; d++) begin
         m_n[d]  = 0;
         m_sc[d] = 0;
         for (int k = 0; k < 16; k++) m_due[d][k] = -1;
      end
      step(1'b0, 1'b0, 1'b1, 1'b0);
      lc = 0;
      step(1'b0, 1'b0, 1'b1, 1'b1);
      step(1'b1, 1'b0, 1'b1, 1'b1);
      step(1'b0, 1'b0, 1'b0, 1'b1);
      checks += 6;
      if (lg_wa[0][1] !== 16'd0) begin errors++; $display("FAIL reset_w_addr got %0d want 0", lg_wa[0][1]); end
      if (lg_vo[0][1] !== 1'b0)  begin errors++; $display("FAIL reset_vld_out got %b want 0", lg_vo[0][1]); end
      if (lg_bz[0][1] !== 1'b0)  begin errors++; $display("FAIL reset_busy got %b want 0", lg_bz[0][1]); end
      if (lg_ns[0][1] !== 1'b0)  begin errors++; $display("FAIL reset_new_sum got %b want 0", lg_ns[0][1]); end
      if (lg_wz[0][1] !== 1'b1)  begin errors++; $display("FAIL reset_w_zero got %b want 1", lg_wz[0][1]); end
      if (lg_wz[0][2] !== 1'b1)  begin errors++; $display("FAIL idle_w_zero got %b want 1", lg_wz[0][2]); end
   endtask

   task automatic test_single_sum();
      lc = 0;
      for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 1'b1);
      idle(8);
      for (int c = 0; c < 12; c++) begin
         checks += 2;
         if (lg_ns[0][c] !== (c == 0)) begin errors++; $display("FAIL single_new_sum cyc %0d got %b want %b", c, lg_ns[0][c], (c == 0)); end
         if (lg_vo[0][c] !== (c == 7)) begin errors++; $display("FAIL single_vld_out cyc %0d got %b want %b", c, lg_vo[0][c], (c == 7)); end
      end
      for (int c = 0; c < 4; c++) begin
         checks++;
         if (lg_wa[0][c] !== 16'(c)) begin errors++; $display("FAIL single_w_addr cyc %0d got %0d want %0d", c, lg_wa[0][c], c); end
      end
   endtask

   task automatic test_back_to_back();
      lc = 0;
      for (int i = 0; i < 12; i++) step(1'b1, 1'b0, 1'b0, 1'b1);
      idle(8);
      for (int c = 0; c < 20; c++) begin
         checks++;
         if (lg_vo[0][c] !== (c == 7 || c == 11 || c == 15)) begin
            errors++; $display("FAIL b2b_vld_out cyc %0d got %b", c, lg_vo[0][c]);
         end
      end
      for (int c = 0; c < 12; c++) begin
         checks += 2;
         if (lg_ns[0][c] !== (c % 4 == 0)) begin errors++; $display("FAIL b2b_new_sum cyc %0d got %b want %b", c, lg_ns[0][c], (c % 4 == 0)); end
         if (lg_wa[0][c] !== 16'(c % 4)) begin errors++; $display("FAIL b2b_w_addr cyc %0d got %0d want %0d", c, lg_wa[0][c], c % 4); end
      end
   endtask

   task automatic test_gap();
      lc = 0;
      step(1'b1, 1'b0, 1'b0, 1'b1);
      step(1'b1, 1'b0, 1'b0, 1'b1);
      idle(3);
      step(1'b1, 1'b0, 1'b0, 1'b1);
      step(1'b1, 1'b0, 1'b0, 1'b1);
      idle(8);
      for (int c = 2; c < 5; c++) begin
         checks += 2;
         if (lg_wz[0][c] !== 1'b1)  begin errors++; $display("FAIL gap_w_zero cyc %0d got %b want 1", c, lg_wz[0][c]); end
         if (lg_wa[0][c] !== 16'd2) begin errors++; $display("FAIL gap_w_addr cyc %0d got %0d want 2", c, lg_wa[0][c]); end
      end
      for (int c = 0; c < 15; c++) begin
         checks++;
         if (lg_vo[0][c] !== (c == 10)) begin errors++; $display("FAIL gap_vld_out cyc %0d got %b want %b", c, lg_vo[0][c], (c == 10)); end
      end
   endtask

   task automatic test_flush();
      lc = 0;
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b1);
      step(1'b1, 1'b1, 1'b0, 1'b1);
      for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 1'b1);
      idle(6);
      checks += 4;
      if (lg_wz[0][3] !== 1'b1)  begin errors++; $display("FAIL flush_w_zero got %b want 1", lg_wz[0][3]); end
      if (lg_ns[0][4] !== 1'b1)  begin errors++; $display("FAIL flush_restart_new_sum got %b want 1", lg_ns[0][4]); end
      if (lg_wa[0][4] !== 16'd0) begin errors++; $display("FAIL flush_restart_w_addr got %0d want 0", lg_wa[0][4]); end
      if (lg_vo[0][11] !== 1'b1) begin errors++; $display("FAIL flush_next_vld_out got %b want 1", lg_vo[0][11]); end
      for (int c = 0; c < 11; c++) begin
         checks++;
         if (lg_vo[0][c] !== 1'b0) begin errors++; $display("FAIL flush_no_vld_out cyc %0d got %b want 0", c, lg_vo[0][c]); end
      end
   endtask

   task automatic test_reset_in_flight();
      lc = 0;
      for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 1'b1);
      idle(1);
      step(1'b0, 1'b0, 1'b1, 1'b1);
      idle(7);
      checks++;
      if (lg_bz[0][4] !== 1'b1) begin errors++; $display("FAIL rst_busy_before got %b want 1", lg_bz[0][4]); end
      for (int c = 0; c < 13; c++) begin
         checks++;
         if (lg_vo[0][c] !== 1'b0) begin errors++; $display("FAIL rst_no_vld_out cyc %0d got %b want 0", c, lg_vo[0][c]); end
      end
      for (int c = 6; c < 13; c++) begin
         checks++;
         if (lg_bz[0][c] !== 1'b0) begin errors++; $display("FAIL rst_busy_after cyc %0d got %b want 0", c, lg_bz[0][c]); end
      end
   endtask

   task automatic test_random();
      logic v, f, r;
      lc = 64;
      for (int i = 0; i < 400; i++) begin
         v = ($urandom_range(99) < 70);
         f = ($urandom_range(99) < 8);
         r = ($urandom_range(99) < 2);
         step(v, f, r, 1'b1);
      end
      idle(6);
   endtask

   task automatic test_single_vector_sums();
      int n_ns, n_vo;
      step(1'b0, 1'b0, 1'b1, 1'b1);
      lc = 0;
      for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 1'b1);
      idle(4);
      n_ns = 0;
      n_vo = 0;
      for (int c = 0; c < 9; c++) begin
         if (lg_ns[1][c] === 1'b1) n_ns++;
         if (lg_vo[1][c] === 1'b1) n_vo++;
      end
      checks += 2;
      if (n_ns != 5) begin errors++; $display("FAIL nc1_new_sum_count got %0d want 5", n_ns); end
      if (n_vo != 5) begin errors++; $display("FAIL nc1_vld_out_count got %0d want 5", n_vo); end
`ifdef MAC_SEQ_SUM_CNT_EN
      checks++;
      if (sc1 !== 16'd5) begin errors++; $display("FAIL nc1_sum_cnt got %0d want 5", sc1); end
`endif
   endtask

   initial begin
      vld_in = 1'b0;
      flush  = 1'b0;
      rst    = 1'b1;
      test_reset();
      test_single_sum();
      test_back_to_back();
      test_gap();
      test_flush();
      test_reset_in_flight();
      test_random();
      test_single_vector_sums();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mac_sequencer.md
MAC_SEQUENCER -- requirements
Module: mac_sequencer

Interface
REQ-001 SHALL have parameter NUM_CYC, default 32: input vectors accumulated per sum, legal range 1..4096.
REQ-002 SHALL have parameter ACC_LAT, default 4: cycles from the last vector on the MAC input to a valid MAC data_out, legal range 1..64.
REQ-003 SHALL have parameter AW, default $clog2(NUM_CYC) (minimum 1): width of w_addr.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port vld_in, input, 1 bit: an input vector is presented to the MAC this cycle.
REQ-007 SHALL have port flush, input, 1 bit: abandon the partial sum in progress.
REQ-008 SHALL have port new_sum, output, 1 bit: drives MAC new_sum; the MAC restarts accumulation with this vector.
REQ-009 SHALL have port w_addr, output, AW bits: weight-ROM index of the current vector.
REQ-010 SHALL have port w_zero, output, 1 bit: forces MAC w_vec to zero so the cycle adds nothing.
REQ-011 SHALL have port vld_out, output, 1 bit: MAC data_out holds a completed sum this cycle.
REQ-012 SHALL have port busy, output, 1 bit: a sum is in progress or results are still in flight.

Function
REQ-013 SHALL implement FSM states IDLE and ACCUM, plus a registered vector counter cnt of AW bits.
REQ-014 w_addr SHALL equal cnt (registered); new_sum and w_zero SHALL be combinational from state, vld_in and flush.
REQ-015 IDLE, vld_in=1, flush=0: new_sum=1; cnt<=1 and go to ACCUM (NUM_CYC>1), otherwise treat the vector as the last.
REQ-016 IDLE with no vector accepted: new_sum=0, w_zero=1, cnt held at 0.
REQ-017 ACCUM, vld_in=1, flush=0: new_sum=0, w_zero=0; if cnt==NUM_CYC-1 it is the last vector (cnt<=0, go to IDLE), otherwise cnt<=cnt+1.
REQ-018 ACCUM, vld_in=0: w_zero=1, cnt and state held (gaps of any length allowed).
REQ-019 A last vector SHALL enter an ACC_LAT-deep shift register; vld_out SHALL assert exactly ACC_LAT cycles after the last-vector cycle, for one cycle.
REQ-020 Back-to-back sums SHALL run with no bubble: a vld_in in the cycle after a last vector starts the next sum with new_sum=1.
REQ-021 The shift register SHALL let up to ACC_LAT sums overlap in flight, one vld_out each.
REQ-022 flush=1: state<=IDLE, cnt<=0, new_sum=0, w_zero=1; a simultaneous vld_in SHALL be dropped; in-flight vld_out pulses SHALL be unaffected.
REQ-023 busy SHALL be (state==ACCUM) OR any shift-register bit set.

Reset
REQ-024 rst=1 SHALL force state IDLE, cnt=0, shift register cleared, and outputs vld_out=0, w_addr=0, busy=0, new_sum=0, w_zero=1.
REQ-025 rst SHALL override vld_in and flush; reset mid-sum or with results in flight SHALL produce no later vld_out.

Configuration
REQ-026 With macro MAC_SEQ_SUM_CNT_EN defined, the block SHALL add output sum_cnt, 16 bits: vld_out pulses since reset, wrapping 0xFFFF->0, cleared by rst and not by flush.
REQ-027 Without MAC_SEQ_SUM_CNT_EN, port sum_cnt and its logic SHALL be absent; all other behaviour is identical.

Verification
REQ-028 NUM_CYC=4, ACC_LAT=4, vld_in high for cycles 0..3 -> new_sum only at cycle 0, w_addr 0,1,2,3, vld_out only at cycle 7.
REQ-029 NUM_CYC=4, vld_in high for 12 consecutive cycles -> new_sum at cycles 0,4,8, vld_out at 7,11,15, w_addr wraps 3->0.
REQ-030 NUM_CYC=4, vld_in at cycles 0,1, low at 2..4, high at 5,6 -> w_zero=1 at cycles 2..4, w_addr held at 2, vld_out at cycle 10.
REQ-031 NUM_CYC=4, vld_in at cycles 0..2, flush with vld_in at cycle 3 -> no vld_out; vld_in at cycle 4 gives new_sum=1, w_addr=0.
REQ-032 Sum completed at cycle 3 (ACC_LAT=4), rst at cycle 5 -> vld_out never asserts, busy=0 from cycle 6.
REQ-033 NUM_CYC=1, with MAC_SEQ_SUM_CNT_EN, vld_in high for 5 cycles -> new_sum=1 on each, 5 vld_out pulses, sum_cnt=5.
